// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitration, operand capture, registered response.
// Optional macro ALU_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins) instead of round-robin.
module alu_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_ctrl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_shamt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_ctrl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_shamt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [4:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   gnt_id;
  logic   winner_c;
  logic   idle_c;
  logic   done_c;

`ifndef ALU_ARB_FIXED_PRI_EN
  logic   rr_ptr;
`endif

  // Winner selection: a lone valid requester always wins; ties go to the preferred one.
  always_comb begin
    winner_c = 1'b0;
`ifdef ALU_ARB_FIXED_PRI_EN
    winner_c = !req0_valid;
`else
    if (req0_valid && req1_valid) begin
      winner_c = rr_ptr;
    end else begin
      winner_c = !req0_valid;
    end
`endif
  end

  assign idle_c     = (state == IDLE) && !reset;
  assign req0_ready = idle_c && req0_valid && !winner_c;
  assign req1_ready = idle_c && req1_valid && winner_c;
  assign done_c     = (state == RESP) && (gnt_id ? rsp1_ready : rsp0_ready);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_id     <= 1'b0;
      alu_ctrl   <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_shamt  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            gnt_id    <= winner_c;
            alu_ctrl  <= winner_c ? req1_ctrl  : req0_ctrl;
            alu_in1   <= winner_c ? req1_a     : req0_a;
            alu_in2   <= winner_c ? req1_b     : req0_b;
            alu_shamt <= winner_c ? req1_shamt : req0_shamt;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp0_valid <= !gnt_id;
          rsp1_valid <= gnt_id;
          state      <= RESP;
        end
        RESP: begin
          // Result stays put until the granted requester consumes it.
          if (done_c) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifndef ALU_ARB_FIXED_PRI_EN
            rr_ptr     <= !gnt_id;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_ctrl  input  4  ALU opcode: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 SLTU, 9 SLL, 10 SRL, 12 NOR.
REQ-007 reqN_a, reqN_b  input  32  operands, mapped to ALU input1 and input2.
REQ-008 reqN_shamt  input  5  shift amount.
REQ-009 rspN_valid  output  1  result for requester N is held.
REQ-010 rspN_ready  input  1  requester N consumes its result.
REQ-011 rsp_result  output  32  registered ALU result, shared by both response ports.
REQ-012 rsp_zero  output  1  registered ALU zero flag.
REQ-013 alu_ctrl, alu_in1, alu_in2, alu_shamt  output  4/32/32/5  drive to the shared ALU.
REQ-014 alu_result, alu_zero  input  32/1  combinational return from the shared ALU.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE: arbiter SHALL pick a winner among the valid requesters and assert only the winner's reqN_ready (combinational, same cycle).
REQ-018 On handshake (valid & ready): latch ctrl, a, b and shamt into operand registers; record the grant id; go to EXEC.
REQ-019 alu_* outputs SHALL be driven only from the operand registers, never directly from request inputs.
REQ-020 EXEC: capture alu_result and alu_zero into rsp_result/rsp_zero; go to RESP.
REQ-021 RESP: assert rspN_valid for the granted N only; hold rsp_result/rsp_zero stable until rspN_ready, then go to IDLE.
REQ-022 Latency: handshake at edge T gives rspN_valid high from T+2. Peak throughput is one operation per 3 cycles.
REQ-023 Both reqN_ready SHALL be low in EXEC and RESP. A requester may drop valid without penalty before it is granted.
REQ-024 Round-robin: rr_ptr selects the preferred requester when both are valid. After each completed response, rr_ptr SHALL point to the requester not just served.
REQ-025 With a single valid requester, it SHALL be granted regardless of rr_ptr.
REQ-026 rspN_ready while rspN_valid is low SHALL be ignored.
REQ-027 Unknown opcodes SHALL pass through unchanged; result is whatever the ALU returns (0 for defaults).

Reset
REQ-028 On reset: state = IDLE, rr_ptr = 0, and operand registers, rsp_result, rsp_zero, rspN_valid, reqN_ready and busy all = 0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight operation with no response; the requester must reissue it.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRI_EN: when defined, requester 0 always wins simultaneous requests and rr_ptr is not implemented. When undefined, REQ-024 round-robin applies.

Verification
REQ-031 Single op: req0 ADD a=5 b=7 accepted at T -> rsp0_valid at T+2, rsp_result=12, rsp_zero=0.
REQ-032 SUB zero: req1 ctrl=6 a=9 b=9 -> rsp_result=0, rsp_zero=1 on rsp1 only; rsp0_valid stays 0.
REQ-033 Contention: both valid continuously after reset, rspN_ready=1 -> grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRI_EN, grants are 0,0,0,0.
REQ-034 Backpressure: rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_result held constant, busy=1, req1_ready=0 throughout; req1 is granted in the cycle after rsp0_ready rises.
REQ-035 Reset in EXEC: reset pulse one cycle after handshake -> no rspN_valid, all outputs 0, next request served normally.
REQ-036 Shift: req0 ctrl=9 b=0x1 shamt=31 -> alu_shamt=31, rsp_result=0x80000000.
